// File: rtl/instr_fields.sv
// instr_fields: one-stage registered decoder for 24-bit instruction words.
// Splits an accepted word into opcode, three register specifiers and a 12-bit
// immediate, and also provides a sign-extended immediate and a NOP flag.
// Every output comes straight from a flop, so no input reaches an output
// within the same cycle.
module instr_fields (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    input  logic [23:0] instruction,
    output logic        out_valid,
    output logic [5:0]  op,
    output logic [1:0]  Rd,
    output logic [1:0]  Rs,
    output logic [1:0]  Rt,
    output logic [11:0] immediate,
    output logic [15:0] imm_sext,
    output logic        is_nop
);

    logic        valid_q, valid_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  rd_q, rd_d;
    logic [1:0]  rs_q, rs_d;
    logic [1:0]  rt_q, rt_d;
    logic [11:0] imm_q, imm_d;
    logic [15:0] sext_q, sext_d;
    logic        nop_q, nop_d;

    // Next-state: stall holds everything; a bubble clears only the valid flag.
    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        imm_d   = imm_q;
        sext_d  = sext_q;
        nop_d   = nop_q;
        if (en) begin
            valid_d = in_valid;
            // Fields are only touched when the word is valid, which keeps
            // undefined bits on idle cycles away from the outputs.
            if (in_valid) begin
                op_d   = instruction[23:18];
                rd_d   = instruction[17:16];
                rs_d   = instruction[15:14];
                rt_d   = instruction[13:12];
                imm_d  = instruction[11:0];
                sext_d = {{4{instruction[11]}}, instruction[11:0]};
                nop_d  = (instruction == 24'h000000);
            end
        end
    end

    // Pipeline register; synchronous reset takes priority over the stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            imm_q   <= '0;
            sext_q  <= '0;
            nop_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            imm_q   <= imm_d;
            sext_q  <= sext_d;
            nop_q   <= nop_d;
        end
    end

    assign out_valid = valid_q;
    assign op        = op_q;
    assign Rd        = rd_q;
    assign Rs        = rs_q;
    assign Rt        = rt_q;
    assign immediate = imm_q;
    assign imm_sext  = sext_q;
    assign is_nop    = nop_q;

endmodule

// File: tb/tb_instr_fields.sv
// tb_instr_fields: directed vectors for instr_fields with hand-computed
// expected field values.
module tb_instr_fields;

    logic        clk;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [23:0] instruction;
    logic        out_valid;
    logic [5:0]  op;
    logic [1:0]  Rd;
    logic [1:0]  Rs;
    logic [1:0]  Rt;
    logic [11:0] immediate;
    logic [15:0] imm_sext;
    logic        is_nop;

    int unsigned n_vec;
    int unsigned n_err;

    instr_fields u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .instruction(instruction),
        .out_valid  (out_valid),
        .op         (op),
        .Rd         (Rd),
        .Rs         (Rs),
        .Rt         (Rt),
        .immediate  (immediate),
        .imm_sext   (imm_sext),
        .is_nop     (is_nop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any mismatch.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [5:0] e_op,
                             input logic [1:0] e_rd, input logic [1:0] e_rs,
                             input logic [1:0] e_rt, input logic [11:0] e_imm,
                             input logic [15:0] e_sext, input logic e_nop);
        check_val({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
        check_val({tag, ".op"},        {26'd0, op},        {26'd0, e_op});
        check_val({tag, ".Rd"},        {30'd0, Rd},        {30'd0, e_rd});
        check_val({tag, ".Rs"},        {30'd0, Rs},        {30'd0, e_rs});
        check_val({tag, ".Rt"},        {30'd0, Rt},        {30'd0, e_rt});
        check_val({tag, ".immediate"}, {20'd0, immediate}, {20'd0, e_imm});
        check_val({tag, ".imm_sext"},  {16'd0, imm_sext},  {16'd0, e_sext});
        check_val({tag, ".is_nop"},    {31'd0, is_nop},    {31'd0, e_nop});
    endtask

    // Apply inputs, take one rising edge, then settle before sampling.
    task automatic step(input logic r, input logic e, input logic v, input logic [23:0] w);
        rst         = r;
        en          = e;
        in_valid    = v;
        instruction = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; en = 1'b1; in_valid = 1'b1; instruction = 24'hFFFFFF;

        // Reset for two cycles with a live all-ones word on the input.
        step(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        step(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        check_all("reset", 1'b0, 6'h00, 2'b00, 2'b00, 2'b00, 12'h000, 16'h0000, 1'b0);

        // 010100_00_11_00_101010101010
        step(1'b0, 1'b1, 1'b1, 24'h50CAAA);
        check_all("split", 1'b1, 6'b010100, 2'b00, 2'b11, 2'b00, 12'hAAA, 16'hFAAA, 1'b0);

        step(1'b0, 1'b1, 1'b1, 24'h000000);
        check_all("zero", 1'b1, 6'h00, 2'b00, 2'b00, 2'b00, 12'h000, 16'h0000, 1'b1);

        step(1'b0, 1'b1, 1'b1, 24'h0007FF);
        check_all("sx7ff", 1'b1, 6'h00, 2'b00, 2'b00, 2'b00, 12'h7FF, 16'h07FF, 1'b0);

        step(1'b0, 1'b1, 1'b1, 24'h000800);
        check_all("sx800", 1'b1, 6'h00, 2'b00, 2'b00, 2'b00, 12'h800, 16'hF800, 1'b0);

        // Load, stall with a new word presented, then a bubble.
        step(1'b0, 1'b1, 1'b1, 24'hABCDEF);
        check_all("load", 1'b1, 6'b101010, 2'b11, 2'b11, 2'b00, 12'hDEF, 16'hFDEF, 1'b0);
        step(1'b0, 1'b0, 1'b1, 24'h123456);
        check_all("stall", 1'b1, 6'b101010, 2'b11, 2'b11, 2'b00, 12'hDEF, 16'hFDEF, 1'b0);
        step(1'b0, 1'b1, 1'b0, 24'hxxxxxx);
        check_all("bubble", 1'b0, 6'b101010, 2'b11, 2'b11, 2'b00, 12'hDEF, 16'hFDEF, 1'b0);
        step(1'b0, 1'b1, 1'b0, 24'h000000);
        check_all("bubble0", 1'b0, 6'b101010, 2'b11, 2'b11, 2'b00, 12'hDEF, 16'hFDEF, 1'b0);

        // Back-to-back words.
        step(1'b0, 1'b1, 1'b1, 24'hFC0000);
        check_all("b2b0", 1'b1, 6'b111111, 2'b00, 2'b00, 2'b00, 12'h000, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 1'b1, 24'h03F000);
        check_all("b2b1", 1'b1, 6'h00, 2'b11, 2'b11, 2'b11, 12'h000, 16'h0000, 1'b0);

        // Reset with stall and a valid word: reset wins, nothing loads.
        step(1'b1, 1'b0, 1'b1, 24'hABCDEF);
        check_all("rst_stall", 1'b0, 6'h00, 2'b00, 2'b00, 2'b00, 12'h000, 16'h0000, 1'b0);

        // Recovery after reset.
        step(1'b0, 1'b1, 1'b1, 24'hFC0800);
        check_all("recover", 1'b1, 6'b111111, 2'b00, 2'b00, 2'b00, 12'h800, 16'hF800, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
